// File: rtl/uno_pkg.sv
// uno_pkg: shared definitions for the uno sequencer slice.
//   - uno_op_t     : PE operation encoding (MAC/div/exp/log)
//   - uno_state_t  : sequencer FSM states (also exported on the debug port)
//   - POINT        : fixed-point 4.8 value used as the div scale/offset term
//   - *_COEFF      : per-op polynomial coefficients, 4.8 fixed point,
//                    index i is the coefficient of x^i
//   - coeff_lookup : (op, index) -> raw coefficient, 0 for MAC
package uno_pkg;

    typedef enum logic [1:0] {
        UNO_MAC = 2'b00,
        UNO_DIV = 2'b01,
        UNO_EXP = 2'b10,
        UNO_LOG = 2'b11
    } uno_op_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MAC_RUN = 3'd1,
        ST_POLY    = 3'd2,
        ST_SCALE   = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_OUT     = 3'd5
    } uno_state_t;

    localparam int COEFF_W = 12;
    localparam int COEFF_N = 8;
    // Coefficient index width; supports polynomial orders up to COEFF_N-1.
    localparam int IDX_W   = 3;

    typedef logic [COEFF_W-1:0] coeff_t;

    localparam coeff_t POINT = 12'h0C0;

    // 1/(1+x) series with the binary-point offset as the constant term.
    localparam coeff_t DIV_COEFF [COEFF_N] = '{
        POINT,   12'hF00, 12'h100, 12'hF00,
        12'h100, 12'hF00, 12'h100, 12'hF00
    };

    // e^x Taylor terms 1/i!.
    localparam coeff_t EXP_COEFF [COEFF_N] = '{
        12'h100, 12'h100, 12'h080, 12'h02B,
        12'h00B, 12'h002, 12'h000, 12'h000
    };

    // ln(1+x) series terms (-1)^(i+1)/i.
    localparam coeff_t LOG_COEFF [COEFF_N] = '{
        12'h000, 12'h100, 12'hF80, 12'h055,
        12'hFC0, 12'h033, 12'hFD5, 12'h025
    };

    function automatic coeff_t coeff_lookup(input uno_op_t op,
                                            input logic [IDX_W-1:0] idx);
        coeff_t c;
        case (op)
            UNO_DIV: c = DIV_COEFF[idx];
            UNO_EXP: c = EXP_COEFF[idx];
            UNO_LOG: c = LOG_COEFF[idx];
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/uno_seq_if.sv
// uno_seq_if: request and result handshakes of the uno sequencer.
//   master : requester / result consumer (drives in_*, res_ready)
//   slave  : the sequencer (drives in_ready, res_*)
//
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid and ready are both high. A source keeps valid and its payload
// stable until that edge; ready may change freely and valid never waits on
// ready combinationally.
interface uno_seq_if #(
    parameter int MAC_BW = 12,
    parameter int CNT_W  = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            in_op;
    logic [MAC_BW-1:0]     in_x;
    logic [MAC_BW-1:0]     in_y;
    logic [2*MAC_BW-1:0]   in_z;
    logic                  in_last;

    logic                  res_valid;
    logic                  res_ready;
    logic [2*MAC_BW-1:0]   res_data;
    logic [CNT_W-1:0]      res_beats;

    modport master (
        output in_valid, in_op, in_x, in_y, in_z, in_last, res_ready,
        input  in_ready, res_valid, res_data, res_beats
    );

    modport slave (
        input  in_valid, in_op, in_x, in_y, in_z, in_last, res_ready,
        output in_ready, res_valid, res_data, res_beats
    );
endinterface

// File: rtl/uno_coeff_rom.sv
// uno_coeff_rom: combinational coefficient lookup for the Horner sequence.
//   op    in  operation (MAC returns 0)
//   idx   in  coefficient index (power of x)
//   coeff out coefficient sign-extended to the PE operand width
module uno_coeff_rom
    import uno_pkg::*;
#(
    parameter int MAC_BW = 12
) (
    input  uno_op_t            op,
    input  logic [IDX_W-1:0]   idx,
    output logic [MAC_BW-1:0]  coeff
);
    coeff_t raw;

    always_comb begin
        raw   = coeff_lookup(op, idx);
        // Coefficients are signed 4.8; sign-extend into wider operands.
        coeff = MAC_BW'($signed(raw));
    end
endmodule

// File: rtl/uno_seq.sv
// uno_seq: control sequencer for the uno processing element.
//   clk, rst_n        clock, asynchronous active-low reset
//   bus (slave)       request handshake in_* and result handshake res_*
//   pe_op/x/y/z/coeff PE operand and op pins, driven cycle by cycle
//   pe_first_cycle    first Horner cycle strobe
//   pe_last_cycle     scale/offset cycle strobe
//   pe_acc_en         PE accumulate enable (0 loads z + x*y)
//   pe_oc             PE accumulator output, registered one cycle in the PE
//   dbg_state         current FSM state
//
// MAC streams beats straight through to the PE in the cycle they are
// accepted; a cycle without a beat drives a zero product with acc_en=1 so
// the accumulator holds. div/exp/log run POLY_ORDER Horner cycles with the
// coefficient of the highest power first, then one scale/offset cycle.
// DRAIN lets the PE register its last update before it is captured.
module uno_seq
    import uno_pkg::*;
#(
    parameter int MAC_BW     = 12,
    parameter int POLY_ORDER = 3,
    parameter int CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uno_seq_if.slave             bus,
    output logic [1:0]           pe_op,
    output logic [MAC_BW-1:0]    pe_x,
    output logic [MAC_BW-1:0]    pe_y,
    output logic [2*MAC_BW-1:0]  pe_z,
    output logic [MAC_BW-1:0]    pe_coeff,
    output logic                 pe_first_cycle,
    output logic                 pe_last_cycle,
    output logic                 pe_acc_en,
    input  logic [2*MAC_BW-1:0]  pe_oc,
    output uno_state_t           dbg_state
);
    localparam logic [IDX_W-1:0] ORDER  = IDX_W'(POLY_ORDER);
    localparam logic [IDX_W-1:0] K_LAST = IDX_W'(POLY_ORDER - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    uno_state_t           state_q, state_d;
    uno_op_t              in_op;
    uno_op_t              op_q;
    logic [MAC_BW-1:0]    x_q, y_q;
    logic [2*MAC_BW-1:0]  z_q;
    logic [IDX_W-1:0]     k_q;
    logic [CNT_W-1:0]     beats_q;
    logic [2*MAC_BW-1:0]  res_data_q;
    logic [CNT_W-1:0]     res_beats_q;
    logic [IDX_W-1:0]     rom_idx;
    logic [MAC_BW-1:0]    rom_coeff;
    logic                 accept;

    assign in_op     = uno_op_t'(bus.in_op);
    assign dbg_state = state_q;

    uno_coeff_rom #(.MAC_BW(MAC_BW)) u_rom (
        .op    (op_q),
        .idx   (rom_idx),
        .coeff (rom_coeff)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        accept         = 1'b0;
        bus.in_ready   = 1'b0;
        rom_idx        = ORDER - k_q;
        // Zero bubble: MAC op with zero product and acc_en=1 holds the PE.
        pe_op          = UNO_MAC;
        pe_x           = '0;
        pe_y           = '0;
        pe_z           = '0;
        pe_coeff       = '0;
        pe_first_cycle = 1'b0;
        pe_last_cycle  = 1'b0;
        pe_acc_en      = 1'b1;

        case (state_q)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept = 1'b1;
                    if (in_op == UNO_MAC) begin
                        // Beat 0 goes to the PE now and loads the bias.
                        pe_x      = bus.in_x;
                        pe_y      = bus.in_y;
                        pe_z      = bus.in_z;
                        pe_acc_en = 1'b0;
                        state_d   = bus.in_last ? ST_DRAIN : ST_MAC_RUN;
                    end else begin
                        state_d = ST_POLY;
                    end
                end
            end
            ST_MAC_RUN: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    pe_x = bus.in_x;
                    pe_y = bus.in_y;
                    pe_z = z_q;
                    if (bus.in_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_POLY: begin
                pe_op          = op_q;
                pe_x           = x_q;
                pe_y           = y_q;
                pe_z           = z_q;
                pe_coeff       = rom_coeff;
                pe_acc_en      = 1'b0;
                pe_first_cycle = (k_q == '0);
                if (k_q == K_LAST) begin
                    state_d = ST_SCALE;
                end
            end
            ST_SCALE: begin
                rom_idx       = '0;
                pe_op         = op_q;
                pe_x          = x_q;
                pe_y          = y_q;
                pe_z          = z_q;
                pe_coeff      = rom_coeff;
                pe_acc_en     = 1'b0;
                pe_last_cycle = 1'b1;
                state_d       = ST_DRAIN;
            end
            ST_DRAIN: begin
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (bus.res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        bus.res_valid = (state_q == ST_OUT);
        bus.res_data  = res_data_q;
        bus.res_beats = res_beats_q;

        // While reset is asserted every output reads 0, including the
        // idle-drive acc_en and in_ready.
        if (!rst_n) begin
            bus.in_ready   = 1'b0;
            bus.res_valid  = 1'b0;
            bus.res_data   = '0;
            bus.res_beats  = '0;
            pe_op          = UNO_MAC;
            pe_x           = '0;
            pe_y           = '0;
            pe_z           = '0;
            pe_coeff       = '0;
            pe_first_cycle = 1'b0;
            pe_last_cycle  = 1'b0;
            pe_acc_en      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= UNO_MAC;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            k_q         <= '0;
            beats_q     <= '0;
            res_data_q  <= '0;
            res_beats_q <= '0;
        end else begin
            if (accept) begin
                op_q    <= in_op;
                x_q     <= bus.in_x;
                y_q     <= bus.in_y;
                z_q     <= bus.in_z;
                k_q     <= '0;
                beats_q <= CNT_ONE;
            end else if (state_q == ST_MAC_RUN && bus.in_valid) begin
                // Saturating beat count.
                if (beats_q != CNT_MAX) begin
                    beats_q <= beats_q + 1'b1;
                end
            end

            if (state_q == ST_POLY) begin
                k_q <= k_q + 1'b1;
            end

            if (state_q == ST_DRAIN) begin
                res_data_q  <= pe_oc;
                res_beats_q <= (op_q == UNO_MAC) ? beats_q : CNT_ONE;
            end
        end
    end
endmodule

// File: tb/tb_uno_seq.sv
// tb_uno_seq: self-checking bench for uno_seq with a behavioural PE.
module tb_uno_seq;
    import uno_pkg::*;

    localparam int MAC_BW     = 12;
    localparam int CNT_W      = 8;
    localparam int POLY_ORDER = 3;
    localparam int DW         = 2 * MAC_BW;
    localparam int W          = DW + CNT_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uno_seq_if #(.MAC_BW(MAC_BW), .CNT_W(CNT_W)) bus ();

    logic [1:0]        pe_op;
    logic [MAC_BW-1:0] pe_x, pe_y, pe_coeff;
    logic [DW-1:0]     pe_z, pe_oc;
    logic              pe_first_cycle, pe_last_cycle, pe_acc_en;
    uno_state_t        dbg_state;

    uno_seq #(.MAC_BW(MAC_BW), .POLY_ORDER(POLY_ORDER), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .pe_op          (pe_op),
        .pe_x           (pe_x),
        .pe_y           (pe_y),
        .pe_z           (pe_z),
        .pe_coeff       (pe_coeff),
        .pe_first_cycle (pe_first_cycle),
        .pe_last_cycle  (pe_last_cycle),
        .pe_acc_en      (pe_acc_en),
        .pe_oc          (pe_oc),
        .dbg_state      (dbg_state)
    );

    // Behavioural PE: MAC mode loads or accumulates x*y; other ops produce
    // an arbitrary value that the sequencer must carry through unchanged.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_oc <= '0;
        end else if (pe_op == 2'b00) begin
            pe_oc <= (pe_acc_en ? pe_oc : pe_z) + DW'(pe_x) * DW'(pe_y);
        end else begin
            pe_oc <= DW'($urandom);
        end
    end

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    // c[j] is the coefficient the PE must see in PE cycle j (j=0 first Horner
    // cycle, j=POLY_ORDER the scale/offset cycle).
    typedef struct packed {
        logic [1:0]        op;
        logic [11:0]       x;
        logic [11:0]       y;
        logic [3:0][11:0]  c;
    } poly_vec_t;

    poly_vec_t pvec[6];

    function automatic poly_vec_t mk_vec(input logic [1:0] op, input logic [11:0] x, input logic [11:0] y,
                                         input logic [11:0] c0, input logic [11:0] c1,
                                         input logic [11:0] c2, input logic [11:0] c3);
        poly_vec_t r;
        r.op   = op;
        r.x    = x;
        r.y    = y;
        r.c[0] = c0;
        r.c[1] = c1;
        r.c[2] = c2;
        r.c[3] = c3;
        return r;
    endfunction

    logic [11:0] bx[300];
    logic [11:0] by[300];

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        bus.in_valid = 1'b0;
        bus.in_op    = 2'b00;
        bus.in_x     = '0;
        bus.in_y     = '0;
        bus.in_z     = '0;
        bus.in_last  = 1'b0;
    endtask

    // Streams n beats from bx/by; bubbles of bmin..bmax cycles between beats.
    task automatic mac_run(input int n, input logic [DW-1:0] z, input int bmin, input int bmax);
        logic [DW-1:0] acc;
        int nb;
        acc = z;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                nb = $urandom_range(bmax, bmin);
                for (int b = 0; b < nb; b++) begin
                    bus.in_valid = 1'b0;
                    bus.in_x     = 12'($urandom);
                    bus.in_y     = 12'($urandom);
                    #1;
                    check("bubble_x", pe_x, 0);
                    check("bubble_y", pe_y, 0);
                    check("bubble_acc_en", pe_acc_en, 1);
                    check("bubble_in_ready", bus.in_ready, 1);
                    tick();
                end
            end
            bus.in_valid = 1'b1;
            bus.in_op    = 2'b00;
            bus.in_x     = bx[i];
            bus.in_y     = by[i];
            bus.in_z     = (i == 0) ? z : DW'($urandom);
            bus.in_last  = (i == n - 1);
            #1;
            check("beat_in_ready", bus.in_ready, 1);
            check("beat_x", pe_x, bx[i]);
            check("beat_y", pe_y, by[i]);
            check("beat_acc_en", pe_acc_en, (i == 0) ? 0 : 1);
            if (i == 0) check("beat0_z", pe_z, z);
            if (i < 3) check("beat_op", pe_op, 0);
            acc = acc + DW'(bx[i]) * DW'(by[i]);
            tick();
        end
        idle_inputs();
        exp_q.push_back({(n > 255) ? 8'd255 : 8'(n), acc});
    endtask

    // One div/exp/log request; optionally holds the next request valid from
    // the cycle after acceptance.
    task automatic poly_run(input int vi, input bit chain, input int ni);
        poly_vec_t v;
        v = pvec[vi];
        bus.in_valid = 1'b1;
        bus.in_op    = v.op;
        bus.in_x     = v.x;
        bus.in_y     = v.y;
        bus.in_z     = DW'($urandom);
        bus.in_last  = 1'($urandom);
        #1;
        check("poly_accept_ready", bus.in_ready, 1);
        check("poly_accept_pe_op", pe_op, 0);
        tick();
        if (chain) begin
            bus.in_valid = 1'b1;
            bus.in_op    = pvec[ni].op;
            bus.in_x     = pvec[ni].x;
            bus.in_y     = pvec[ni].y;
        end else begin
            idle_inputs();
        end
        #1;
        for (int k = 0; k <= POLY_ORDER; k++) begin
            check("poly_pe_op", pe_op, v.op);
            check("poly_pe_x", pe_x, v.x);
            check("poly_pe_y", pe_y, v.y);
            check("poly_coeff", pe_coeff, v.c[k]);
            check("poly_first", pe_first_cycle, (k == 0) ? 1 : 0);
            check("poly_last", pe_last_cycle, (k == POLY_ORDER) ? 1 : 0);
            check("poly_in_ready", bus.in_ready, 0);
            check("poly_res_valid", bus.res_valid, 0);
            tick();
        end
        check("drain_pe_op", pe_op, 0);
        check("drain_pe_x", pe_x, 0);
        check("drain_acc_en", pe_acc_en, 1);
        check("drain_strobes", {pe_first_cycle, pe_last_cycle}, 0);
        check("drain_in_ready", bus.in_ready, 0);
        exp_q.push_back({8'd1, pe_oc});
    endtask

    // Waits for the result (expected one cycle after DRAIN), holds it for
    // 'hold' cycles of backpressure, then consumes it.
    task automatic get_result(input int hold);
        int w;
        logic [W-1:0] e;
        w = 0;
        while (!bus.res_valid && w < 20) begin
            tick();
            w++;
        end
        check("res_latency", w, 1);
        if (exp_q.size() == 0) begin
            check("exp_q_nonempty", 0, 1);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        if (bus.res_valid) begin
            for (int h = 0; h < hold; h++) begin
                check("bp_res_valid", bus.res_valid, 1);
                check("bp_res_data", bus.res_data, e[DW-1:0]);
                check("bp_res_beats", bus.res_beats, e[W-1:DW]);
                check("bp_in_ready", bus.in_ready, 0);
                tick();
            end
            bus.res_ready = 1'b1;
            #1;
            check("res_data", bus.res_data, e[DW-1:0]);
            check("res_beats", bus.res_beats, e[W-1:DW]);
            check("out_in_ready", bus.in_ready, 0);
            check("out_pe_op", pe_op, 0);
            tick();
            bus.res_ready = 1'b0;
            #1;
            check("post_res_valid", bus.res_valid, 0);
            check("post_in_ready", bus.in_ready, 1);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int hi;
        int n;
        pvec[0] = mk_vec(2'b10, 12'h180, 12'h000, 12'h02B, 12'h080, 12'h100, 12'h100);
        pvec[1] = mk_vec(2'b01, 12'h200, 12'h0C0, 12'hF00, 12'h100, 12'hF00, 12'h0C0);
        pvec[2] = mk_vec(2'b11, 12'h040, 12'h000, 12'h055, 12'hF80, 12'h100, 12'h000);
        pvec[3] = mk_vec(2'b10, 12'hFFF, 12'hFFF, 12'h02B, 12'h080, 12'h100, 12'h100);
        pvec[4] = mk_vec(2'b01, 12'h001, 12'h800, 12'hF00, 12'h100, 12'hF00, 12'h0C0);
        pvec[5] = mk_vec(2'b11, 12'h7FF, 12'h123, 12'h055, 12'hF80, 12'h100, 12'h000);

        rst_n = 1'b0;
        bus.res_ready = 1'b0;
        idle_inputs();
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_acc_en", pe_acc_en, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("idle_in_ready", bus.in_ready, 1);
        check("idle_acc_en", pe_acc_en, 1);
        check("idle_state", dbg_state, ST_IDLE);
        tick();

        // MAC (2,3),(4,5),(1,1), z=10 without and with 2-cycle bubbles.
        bx[0] = 12'd2; by[0] = 12'd3;
        bx[1] = 12'd4; by[1] = 12'd5;
        bx[2] = 12'd1; by[2] = 12'd1;
        mac_run(3, 24'd10, 0, 0);
        get_result(0);
        mac_run(3, 24'd10, 2, 2);
        get_result(0);

        // exp x=0x180, then div with 5 cycles of result backpressure.
        poly_run(0, 1'b0, 0);
        get_result(0);
        poly_run(1, 1'b0, 0);
        get_result(5);

        // div then log back to back.
        poly_run(1, 1'b1, 2);
        get_result(0);
        poly_run(2, 1'b0, 0);
        get_result(0);

        // Reset at k=1 of an exp request.
        bus.in_valid = 1'b1;
        bus.in_op    = 2'b10;
        bus.in_x     = 12'h180;
        #1;
        tick();
        idle_inputs();
        tick();
        check("rstmid_first_off", pe_first_cycle, 0);
        rst_n = 1'b0;
        #1;
        check("rstmid_pe_op", pe_op, 0);
        check("rstmid_pe_xy", {pe_x, pe_y}, 0);
        check("rstmid_pe_z", pe_z, 0);
        check("rstmid_coeff", pe_coeff, 0);
        check("rstmid_strobes", {pe_first_cycle, pe_last_cycle, pe_acc_en}, 0);
        check("rstmid_res_valid", bus.res_valid, 0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("rstmid_in_ready", bus.in_ready, 1);
        check("rstmid_state", dbg_state, ST_IDLE);
        hi = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.res_valid) hi++;
        end
        check("rstmid_no_result", hi, 0);

        // Whole table with random backpressure.
        for (int i = 0; i < 6; i++) begin
            poly_run(i, 1'b0, 0);
            get_result($urandom_range(2, 0));
        end

        // Random MAC transactions.
        for (int t = 0; t < 10; t++) begin
            n = $urandom_range(6, 1);
            for (int i = 0; i < n; i++) begin
                bx[i] = 12'($urandom);
                by[i] = 12'($urandom);
            end
            mac_run(n, DW'($urandom), 0, 2);
            get_result($urandom_range(2, 0));
        end

        // Beat counter saturation.
        for (int i = 0; i < 260; i++) begin
            bx[i] = 12'($urandom_range(15, 0));
            by[i] = 12'($urandom_range(15, 0));
        end
        mac_run(260, 24'd5, 0, 0);
        get_result(1);

        check("exp_q_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uno_seq.md
Name: uno_seq

Overview:
- Upstream control sequencer for the uno processing element.
- Accepts operation requests over a valid/ready handshake and drives the PE's control and operand pins cycle by cycle:
  - op, X, Y, Z, coeff, first/last cycle strobes, acc_en.
- Sequences Horner evaluation for div/exp/log and streaming dot-product accumulation for MAC.
- Captures the PE accumulator output and returns it on a registered result handshake.

Parameters:
- MAC_BW, 12, PE operand width; Z and results are 2*MAC_BW.
- POLY_ORDER, 3, polynomial order for div/exp/log.
  - Horner issue cycles = POLY_ORDER; total PE cycles = POLY_ORDER+1 including the scale/offset cycle.
- CNT_W, 8, width of the MAC beat counter; saturates at 2^CNT_W-1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request/beat valid
- in_ready  out  1  sequencer accepts beat
- in_op  in  2  00 MAC, 01 div, 10 exp, 11 log; sampled on the first beat only
- in_x  in  MAC_BW  operand X
- in_y  in  MAC_BW  operand Y (MAC, div)
- in_z  in  2*MAC_BW  MAC bias; first beat only
- in_last  in  1  final MAC beat; ignored for non-MAC ops
- pe_op  out  2  to PE op
- pe_x  out  MAC_BW  to PE X
- pe_y  out  MAC_BW  to PE Y
- pe_z  out  2*MAC_BW  to PE Z
- pe_coeff  out  MAC_BW  to PE coeff
- pe_first_cycle  out  1  to PE first-cycle strobe
- pe_last_cycle  out  1  to PE last-cycle strobe
- pe_acc_en  out  1  to PE acc_en
- pe_oc  in  2*MAC_BW  PE accumulator register output
- res_valid  out  1  result valid
- res_ready  in  1  result consumed
- res_data  out  2*MAC_BW  result
- res_beats  out  CNT_W  MAC beats accumulated; 1 for non-MAC ops

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE; all outputs 0, with in_ready=1 in IDLE. Reset mid-operation abandons the operation; no result is emitted.
- States: IDLE, MAC_RUN, POLY, SCALE, DRAIN, OUT.
- IDLE, on in_valid:
  - latch op, x, y, and the operands to hold for the whole operation.
  - op=00 -> MAC_RUN, treating the accepted beat as beat 0.
  - op!=00 -> POLY with k=0.
- MAC_RUN:
  - in_ready=1.
  - Accepted beat: pe_x=in_x, pe_y=in_y.
    - Beat 0: pe_acc_en=0, pe_z=in_z.
    - Later beats: pe_acc_en=1.
  - No beat (bubble): pe_x=0, pe_y=0, pe_acc_en=1, so the PE holds its accumulator. Bubbles are unlimited.
  - Beat with in_last=1 -> DRAIN.
  - The beat counter saturates; it does not wrap.
- POLY, k=0..POLY_ORDER-1:
  - in_ready=0.
  - pe_op=latched op; pe_x, pe_y held.
  - pe_coeff = ROM(op, POLY_ORDER-k).
  - pe_first_cycle=1 when k=0 only.
  - After k=POLY_ORDER-1 -> SCALE.
- SCALE:
  - One cycle; pe_last_cycle=1.
  - pe_coeff = ROM(op, 0).
  - -> DRAIN.
- DRAIN:
  - One cycle; PE driven to hold (MAC-mode zero bubble, op=00).
  - res_data <= pe_oc, which is valid because the PE MAC output is registered one cycle.
  - -> OUT.
- OUT:
  - res_valid=1; res_data and res_beats held stable until res_ready.
  - res_ready=1 -> IDLE.
  - in_ready=0 while in OUT; no new request is accepted in the cycle the result is consumed.
- Latency:
  - Non-MAC, request accepted at edge 0: POLY in cycles 1..POLY_ORDER, SCALE in cycle POLY_ORDER+1, DRAIN in POLY_ORDER+2. res_valid is high from cycle POLY_ORDER+3 (6 at default).
  - MAC: res_valid goes high 2 cycles after the edge that accepts the last beat.
- Idle PE drive: in IDLE/OUT the PE is driven as a zero bubble (op=00, x=y=0, acc_en=1).
- pe_first_cycle and pe_last_cycle are never high together, and are never high when pe_op=00.
- Arithmetic is performed entirely in the PE; the sequencer only moves values, with no truncation.

Decomposition:
- Shared package uno_pkg holds:
  - op encoding typedef (UNO_MAC, UNO_DIV, UNO_EXP, UNO_LOG);
  - state enum;
  - POINT constant 12'h0C0;
  - per-op coefficient constant arrays in fixed-point 4.8.
- One sub-module, uno_coeff_rom: combinational (op, index) -> coeff from package constants; returns 0 for op=00.

Test Plan:
- Reset mid-POLY (rst_n low at k=1):
  - all pe_* and res_valid are 0 immediately;
  - in_ready=1 after release;
  - no result appears.
- MAC 3 beats, (2,3), (4,5), (1,1), z=10, no bubbles:
  - acc_en pattern 0,1,1;
  - res_data = 10+6+20+1 = 37, res_beats=3, 2 cycles after the last beat.
- MAC with a 2-cycle bubble between beats:
  - pe_x=pe_y=0, acc_en=1 during the bubble;
  - result unchanged from the no-bubble case (37).
- Exp request, x=12'h180:
  - pe_first_cycle in cycle 1, pe_last_cycle in cycle 4;
  - pe_coeff sequence ROM(exp,3), ROM(exp,2), ROM(exp,1), ROM(exp,0);
  - in_ready=0 throughout;
  - res_valid at cycle 6 with res_data equal to the value driven on pe_oc in cycle 5.
- Result backpressure:
  - res_ready held low 5 cycles: res_valid and res_data stable, in_ready=0;
  - res_ready high: next cycle returns to IDLE with in_ready=1.
- Back-to-back div then log:
  - second in_valid held from the cycle after the first is accepted; it is accepted only after the first result is consumed;
  - pe_op switches 01 -> 00 (DRAIN/OUT) -> 11.
